// File: rtl/audio_codec_port_if.sv
// audio_codec_port_if: sample handshake between the play/record controller and the codec port
interface audio_codec_port_if;
   logic [32:1] audio_out;
   logic        write_audio_out;
   logic        audio_out_allowed;
   logic [32:1] audio_in;
   logic        audio_in_available;
   logic        read_audio_in;
   logic        clear_flags;
   logic        underflow;
   logic        overflow;
   modport master (
      output audio_out, write_audio_out, read_audio_in, clear_flags,
      input  audio_out_allowed, audio_in, audio_in_available, underflow, overflow
   );
   modport slave (
      input  audio_out, write_audio_out, read_audio_in, clear_flags,
      output audio_out_allowed, audio_in, audio_in_available, underflow, overflow
   );
endinterface

// File: rtl/audio_codec_port.sv
// audio_codec_port: I2S codec endpoint with show-ahead DAC/ADC sample FIFOs and BCLK/LRCK generation
module audio_codec_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_push,
   input  logic        i_pop,
   input  logic [31:0] i_din,
   output logic [31:0] o_head,
   output logic        o_full,
   output logic        o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_pop;
   logic          w_push;
   assign o_empty = r_cnt == '0;
   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign w_pop   = i_pop & ~o_empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_head  = o_empty ? '0 : r_mem[r_rd];
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         r_wr  <= r_wr + AW'(w_push);
         r_rd  <= r_rd + AW'(w_pop);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   always_ff @(posedge i_clk)
      if (w_push) r_mem[r_wr] <= i_din;
endmodule

module audio_codec_port #(
   parameter int BCLK_DIV   = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   audio_codec_port_if.slave  bus,
   output logic               aud_bclk,
   output logic               aud_daclrck,
   output logic               aud_dacdat,
   input  logic               aud_adcdat
);
   localparam int DW = $clog2(BCLK_DIV);
   logic [DW-1:0] r_div;
   logic          r_bclk;
   logic [5:0]    r_bit;
   logic          r_dacdat;
   logic [32:1]   r_tx;
   logic [15:0]   r_left;
   logic [15:0]   r_right;
   logic          r_push;
   logic          r_uf;
   logic          r_of;
   logic [5:0]    w_nbit;
   logic [4:0]    w_slot;
   logic [4:0]    w_rslot;
   logic          w_tick;
   logic          w_fall;
   logic          w_rise;
   logic          w_start;
   logic          w_dat;
   logic          w_dac_full;
   logic          w_dac_empty;
   logic          w_adc_full;
   logic          w_adc_empty;
   logic          w_adc_drop;
   logic [31:0]   w_dac_head;
   logic [31:0]   w_adc_head;
   assign w_tick  = r_div == DW'(BCLK_DIV - 1);
   assign w_fall  = w_tick & r_bclk;
   assign w_rise  = w_tick & ~r_bclk;
   assign w_nbit  = r_bit + 6'd1;
   assign w_slot  = w_nbit[4:0];
   assign w_rslot = r_bit[4:0];
   assign w_start = w_fall & (w_nbit == 6'd0);
   // data trails LRCK by one BCLK: slot s carries word bit 16-s+1 of the current half, MSB first
   assign w_dat   = (w_slot != 5'd0 && w_slot <= 5'd16) ?
                    r_tx[w_nbit[5] ? 6'd17 - {1'b0, w_slot} : 6'd33 - {1'b0, w_slot}] : 1'b0;
   assign w_adc_drop = r_push & w_adc_full & ~bus.read_audio_in;
   assign aud_bclk    = r_bclk;
   assign aud_daclrck = r_bit[5];
   assign aud_dacdat  = r_dacdat;
   assign bus.audio_out_allowed  = ~w_dac_full;
   assign bus.audio_in_available = ~w_adc_empty;
   assign bus.audio_in           = w_adc_head;
   assign bus.underflow          = r_uf;
   assign bus.overflow           = r_of;
   audio_codec_fifo #(.DEPTH(FIFO_DEPTH)) u_dac (
      .i_clk(CLOCK_50), .i_rst_n(resetn), .i_push(bus.write_audio_out), .i_pop(w_start),
      .i_din(bus.audio_out), .o_head(w_dac_head), .o_full(w_dac_full), .o_empty(w_dac_empty)
   );
   audio_codec_fifo #(.DEPTH(FIFO_DEPTH)) u_adc (
      .i_clk(CLOCK_50), .i_rst_n(resetn), .i_push(r_push), .i_pop(bus.read_audio_in),
      .i_din({r_left, r_right}), .o_head(w_adc_head), .o_full(w_adc_full), .o_empty(w_adc_empty)
   );
   always_ff @(posedge CLOCK_50 or negedge resetn)
      if (!resetn) begin
         r_div    <= '0;
         r_bclk   <= 1'b0;
         r_bit    <= '0;
         r_dacdat <= 1'b0;
         r_tx     <= '0;
         r_left   <= '0;
         r_right  <= '0;
         r_push   <= 1'b0;
         r_uf     <= 1'b0;
         r_of     <= 1'b0;
      end else begin
         r_div  <= w_tick ? '0 : r_div + DW'(1);
         r_bclk <= r_bclk ^ w_tick;
         r_push <= w_rise & (r_bit == 6'd48);
         r_uf   <= (w_start & w_dac_empty) | (r_uf & ~bus.clear_flags);
         r_of   <= w_adc_drop | (r_of & ~bus.clear_flags);
         if (w_fall) begin
            r_bit    <= w_nbit;
            r_dacdat <= w_dat;
         end
         if (w_start) r_tx <= w_dac_empty ? '0 : w_dac_head;
         if (w_rise && w_rslot != 5'd0 && w_rslot <= 5'd16) begin
            if (r_bit[5]) r_right <= {r_right[14:0], aud_adcdat};
            else          r_left  <= {r_left[14:0], aud_adcdat};
         end
      end
endmodule

// File: tb/tb_audio_codec_port.sv
// tb_audio_codec_port: directed + random checks of audio_codec_port against a frame-level reference model
module tb_audio_codec_port;
   logic CLOCK_50 = 1'b0;
   logic resetn = 1'b1;
   logic aud_adcdat = 1'b0;
   logic aud_bclk, aud_daclrck, aud_dacdat;
   logic lb = 1'b0;
   int n_checks = 0;
   int n_fails = 0;
   int n = 0;
   logic [31:0] q_dac[$];
   logic [31:0] q_adc[$];
   logic [31:0] m_tx;
   logic [15:0] m_l, m_r;
   logic m_pend, m_dac, m_uf, m_of;
   logic [63:0] cap = '0;

   audio_codec_port_if bus();
   audio_codec_port #(.BCLK_DIV(2), .FIFO_DEPTH(8)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .bus(bus), .aud_bclk(aud_bclk),
      .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat), .aud_adcdat(aud_adcdat)
   );
   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic model_reset();
      n = 0;
      q_dac.delete();
      q_adc.delete();
      m_tx = '0; m_l = '0; m_r = '0;
      m_pend = 0; m_dac = 0; m_uf = 0; m_of = 0;
   endtask

   // one CLOCK_50 edge of the spec: BCLK edge every 2 cycles, one bit per 4, one frame per 256
   task automatic model_edge();
      int b, s, dsz, asz;
      logic uf_set, of_set, dpop, apop;
      n++;
      b = (n / 4) % 64;
      s = b % 32;
      dsz = q_dac.size();
      asz = q_adc.size();
      uf_set = 0; of_set = 0; dpop = 0;
      if (n % 256 == 0) begin
         if (dsz > 0) begin m_tx = q_dac.pop_front(); dpop = 1; end
         else begin m_tx = '0; uf_set = 1; end
      end
      if (bus.write_audio_out && (dsz < 8 || dpop)) q_dac.push_back(bus.audio_out);
      apop = bus.read_audio_in && asz > 0;
      if (apop) void'(q_adc.pop_front());
      if (m_pend) begin
         if (asz < 8 || apop) q_adc.push_back({m_l, m_r});
         else of_set = 1;
      end
      m_pend = 0;
      if (n % 4 == 0) m_dac = (s >= 1 && s <= 16) ? m_tx[b < 32 ? 32 - s : 16 - s] : 1'b0;
      if (n % 4 == 2 && s >= 1 && s <= 16) begin
         if (b < 32) m_l = {m_l[14:0], aud_adcdat};
         else m_r = {m_r[14:0], aud_adcdat};
         m_pend = (b == 48);
      end
      m_uf = uf_set | (m_uf & ~bus.clear_flags);
      m_of = of_set | (m_of & ~bus.clear_flags);
   endtask

   task automatic compare_all();
      check("bclk", aud_bclk, 64'((n / 2) % 2));
      check("lrck", aud_daclrck, 64'(((n / 4) % 64) >= 32));
      check("dacdat", aud_dacdat, m_dac);
      check("allowed", bus.audio_out_allowed, 64'(q_dac.size() < 8));
      check("available", bus.audio_in_available, 64'(q_adc.size() > 0));
      check("audio_in", bus.audio_in, q_adc.size() > 0 ? q_adc[0] : 32'h0);
      check("underflow", bus.underflow, m_uf);
      check("overflow", bus.overflow, m_of);
   endtask

   task automatic tick();
      model_edge();
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      if (n % 4 == 0) cap = {cap[62:0], aud_dacdat};
      compare_all();
      if (lb) aud_adcdat = m_dac;
   endtask

   task automatic run_until(input int ph);
      tick();
      while (n % 256 != ph) tick();
   endtask

   task automatic write_word(input logic [31:0] w);
      bus.write_audio_out = 1'b1;
      bus.audio_out = w;
      tick();
      bus.write_audio_out = 1'b0;
   endtask

   task automatic read_word();
      bus.read_audio_in = 1'b1;
      tick();
      bus.read_audio_in = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      check("rst_bclk", aud_bclk, 0);
      check("rst_lrck", aud_daclrck, 0);
      check("rst_dacdat", aud_dacdat, 0);
      check("rst_audio_in", bus.audio_in, 0);
      check("rst_available", bus.audio_in_available, 0);
      check("rst_allowed", bus.audio_out_allowed, 1);
      check("rst_underflow", bus.underflow, 0);
      check("rst_overflow", bus.overflow, 0);
      model_reset();
      repeat (3) @(negedge CLOCK_50);
      resetn = 1'b1;
   endtask

   initial begin
      bus.audio_out = '0;
      bus.write_audio_out = 1'b0;
      bus.read_audio_in = 1'b0;
      bus.clear_flags = 1'b0;
      @(negedge CLOCK_50);
      do_reset();
      // idle: first frame start finds the DAC FIFO empty
      run_until(255);
      check("uf_before_start", bus.underflow, 0);
      tick();
      check("uf_after_start", bus.underflow, 1);
      check("allowed_idle", bus.audio_out_allowed, 1);
      // serial pattern with loopback into the ADC
      lb = 1'b1;
      aud_adcdat = m_dac;
      write_word(32'hA5A5_3C3C);
      run_until(0);
      for (int i = 0; i < 16 && q_adc.size() > 0; i++) read_word();
      run_until(252);
      check("dac_frame_a5a5", cap, {1'b0, 16'hA5A5, 15'h0, 1'b0, 16'h3C3C, 15'h0});
      check("adc_loop_a5a5", bus.audio_in, 32'hA5A5_3C3C);
      read_word();
      write_word(32'h1234_8001);
      run_until(194);
      check("avail_before_push", bus.audio_in_available, 0);
      tick();
      check("avail_after_push", bus.audio_in_available, 1);
      check("adc_loop_1234", bus.audio_in, 32'h1234_8001);
      read_word();
      check("avail_after_read", bus.audio_in_available, 0);
      // random traffic
      lb = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         bus.write_audio_out = $urandom_range(0, 7) == 0;
         bus.audio_out = $urandom;
         bus.read_audio_in = $urandom_range(0, 3) == 0;
         bus.clear_flags = $urandom_range(0, 63) == 0;
         aud_adcdat = 1'($urandom_range(0, 1));
         tick();
      end
      bus.write_audio_out = 1'b0;
      bus.read_audio_in = 1'b0;
      bus.clear_flags = 1'b0;
      for (int i = 0; i < 2600 && q_dac.size() > 0; i++) tick();
      for (int i = 0; i < 16 && q_adc.size() > 0; i++) read_word();
      // write landing on an empty frame-start pop, then overfill
      run_until(254);
      bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      write_word($urandom);
      check("uf_coincide", bus.underflow, 1);
      check("allowed_coincide", bus.audio_out_allowed, 1);
      for (int i = 1; i < 10; i++) write_word($urandom);
      check("allowed_full", bus.audio_out_allowed, 0);
      repeat (9 * 256) tick();
      check("allowed_drained", bus.audio_out_allowed, 1);
      // ADC overflow with no reads
      run_until(0);
      for (int i = 0; i < 16 && q_adc.size() > 0; i++) read_word();
      bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      aud_adcdat = 1'b1;
      repeat (9) run_until(0);
      check("overflow_set", bus.overflow, 1);
      check("adc_full_head", bus.audio_in, 32'hFFFF_FFFF);
      bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      check("overflow_clr", bus.overflow, 0);
      run_until(194);
      read_word();
      check("overflow_rw_full", bus.overflow, 0);
      for (int i = 0; i < 8; i++) read_word();
      check("adc_count8", bus.audio_in_available, 0);
      // reset in the middle of a frame with both FIFOs holding data
      for (int i = 0; i < 3; i++) write_word($urandom);
      run_until(196);
      run_until(80);
      check("pre_rst_avail", bus.audio_in_available, 1);
      do_reset();
      tick();
      check("post_rst_avail", bus.audio_in_available, 0);
      check("post_rst_allowed", bus.audio_out_allowed, 1);
      repeat (300) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/audio_codec_port.md
Name: audio_codec_port

Overview:
- Codec-side endpoint of the audio sample handshake that the play/record controller drives.
- Accepts 32-bit playback words, buffers them, and serializes them to the codec DAC over I2S.
- Deserializes codec ADC I2S data into 32-bit record words and presents them through a show-ahead FIFO.
- Generates BCLK/LRCK from the system clock. Single clock domain, sits between the controller and the codec pins.

Parameters:
- BCLK_DIV, 16, system-clock cycles per BCLK half-period (≥2). BCLK = CLOCK_50/(2*BCLK_DIV).
- FIFO_DEPTH, 8, words per FIFO (power of 2, ≥2).

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- audio_out  in  32 (bits 32:1)  playback word: bits 32:17 = left, 16:1 = right
- write_audio_out  in  1  push audio_out into DAC FIFO
- audio_out_allowed  out  1  DAC FIFO not full
- audio_in  out  32 (bits 32:1)  head of ADC FIFO, same packing as audio_out
- audio_in_available  out  1  ADC FIFO not empty
- read_audio_in  in  1  pop ADC FIFO
- clear_flags  in  1  synchronous clear of underflow/overflow
- aud_bclk  out  1  I2S bit clock
- aud_daclrck  out  1  frame clock: 0 = left half, 1 = right half (also used for ADC)
- aud_dacdat  out  1  serial DAC data
- aud_adcdat  in  1  serial ADC data
- underflow  out  1  sticky: frame start found DAC FIFO empty
- overflow  out  1  sticky: ADC word dropped, FIFO full

Behaviour:
- Reset (async, resetn=0) clears all counters and FIFOs.
  - aud_bclk=0, aud_daclrck=0, aud_dacdat=0, audio_in=0, audio_in_available=0, audio_out_allowed=1, underflow=0, overflow=0.
  - Mid-frame reset aborts the frame. After release the first frame starts at bit 0.
- Clock divider: div_cnt counts 0..BCLK_DIV-1 and aud_bclk toggles on wrap. A "fall" event is bclk 1→0; a "rise" event is bclk 0→1.
- Bit counter bit_cnt[5:0] advances on each fall and wraps 63→0.
  - aud_daclrck = bit_cnt[5], updated with bit_cnt.
  - Half-frame slot s = bit_cnt[4:0].
- DAC path:
  - On a fall that makes bit_cnt=0 (frame start), pop the DAC FIFO head into shift register tx.
  - If the DAC FIFO is empty at that point, load tx=0 and set underflow.
  - aud_dacdat is registered on falls: slots 1..16 carry left (bit_cnt<32) or right MSB-first; slot 0 and slots 17..31 drive 0 (I2S one-BCLK delay).
- ADC path:
  - On each rise with slot 1..16, shift aud_adcdat into the left or right 16-bit register, MSB first.
  - After the rise at right slot 16 (bit_cnt=48), push {left,right} into the ADC FIFO on the next system clock.
  - If the ADC FIFO is full, drop the word and set overflow.
- FIFOs are synchronous, show-ahead, FIFO_DEPTH entries.
  - audio_out_allowed = !dac_full. audio_in_available = !adc_empty. audio_in = adc head, or 0 when empty. All combinational from FIFO state.
  - write_audio_out while full is ignored with no flag.
  - read_audio_in while empty is ignored.
  - Simultaneous push and pop on the same FIFO in one cycle are both performed and the count is unchanged; on a full FIFO this is legal.
  - An internal frame-start pop coinciding with write_audio_out on an empty FIFO: the pop sees empty (underflow, tx=0) and the written word stays queued.
- Pointers wrap modulo FIFO_DEPTH. The count is one bit wider than the pointers to distinguish full from empty.
- clear_flags clears underflow/overflow. If a set event occurs in the same cycle, set wins.
- Latency:
  - A word written into an empty DAC FIFO appears on aud_dacdat at the next frame's slot 1. Worst case is one frame (64 BCLK) plus one BCLK.
  - An ADC word is available 1 CLOCK_50 after the bit_cnt=48 rise.

Test Plan:
- Reset then idle, BCLK_DIV=2 → aud_bclk period 4 cycles, aud_daclrck period 256 cycles, aud_dacdat=0, underflow=1 after the first frame start, audio_out_allowed=1.
- Write 32'hA5A5_3C3C, observe aud_dacdat → left slots 1..16 = 1010010110100101, right = 0011110000111100, slots 0 and 17..31 = 0.
- Loopback aud_adcdat=aud_dacdat, write 32'h1234_8001 → audio_in_available rises after bit 48 of the same frame, audio_in=32'h1234_8001, read_audio_in drops available.
- Write FIFO_DEPTH+2 words with no frame start → audio_out_allowed=0 after 8 writes, extra 2 discarded, subsequent frames emit the first 8 words in order.
- aud_adcdat held 1, no reads for 9 frames → 8 words of 32'hFFFF_FFFF queued, overflow=1; clear_flags → overflow=0; simultaneous read+push at full keeps count 8.
- Assert resetn low at bit_cnt=20 with both FIFOs non-empty → all outputs at reset values immediately, FIFOs empty after release.
